led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Mode controller for the 4-bit board LED bank. It divides the 50 MHz system clock into a step tick and sequences the LEDs through four display modes: off, blink, water (running light) and breathe (PWM). A single-cycle request pulse from the debounced key logic advances the mode, and a hold input freezes animation. Sits between the key debouncer and the LED pins and supersedes the fixed single-pattern LED driver.

Parameters:
T, 26'd50_000_000, clock cycles per step tick (1 s at 50 MHz); benches override it to 26'd10.
LED_W, 4, number of LEDs driven.
PWM_W, 8, PWM counter and duty width for breathe mode.

Ports:
clk  input  1  system clock, 50 MHz.
rst  input  1  asynchronous reset, active-high.
mode_next  input  1  single-cycle pulse; advances the mode.
hold  input  1  level; freezes the tick counter and the pattern.
led  output  LED_W  registered LED drive, 1 = on.
mode  output  2  current mode: 0 OFF, 1 BLINK, 2 WATER, 3 BREATHE.
tick  output  1  one-cycle step pulse.

Behaviour:
- Reset (async, rst=1): mode=OFF, led=0, tick=0, tick counter=0, pwm_cnt=0, duty=0, dir=UP. Outputs hold these values while rst is high.
- Tick generator: tick_cnt counts 0..T-1. tick=1 for exactly one cycle when tick_cnt==T-1, then tick_cnt wraps to 0. Tick period is T cycles.
- Hold: while hold=1, tick_cnt freezes, no tick is issued and the pattern state freezes. led keeps its value, except in BREATHE, where pwm_cnt keeps running so brightness stays constant.
- mode_next: the edge after the pulse does the following:
  - mode advances 0→1→2→3→0 (wraps).
  - tick_cnt clears to 0.
  - pattern state initialises for the new mode.
  - mode_next takes effect even while hold=1.
  - If mode_next and tick coincide, mode_next wins and the tick's pattern step is discarded. tick is still asserted that cycle.
- OFF: led=0 constant.
- BLINK: led initialises to all ones. Each tick, led inverts (all-ones ↔ all-zeros).
- WATER: led initialises to one-hot 4'b0001. Each tick, led rotates left, so 4'b1000 wraps to 4'b0001.
- BREATHE:
  - pwm_cnt (PWM_W bits) free-runs and wraps.
  - led is registered as all bits = (pwm_cnt < duty), giving one cycle of latency from the compare.
  - Each tick, when dir=UP:
    - if duty == 2^PWM_W-1: dir becomes DOWN and duty decrements;
    - otherwise duty increments.
  - Each tick, when dir=DOWN:
    - if duty == 0: dir becomes UP and duty increments;
    - otherwise duty decrements.
  - duty=0 keeps led fully off. duty=max gives led on for 255 of 256 cycles.
  - Entering BREATHE: duty=0, dir=UP.
- Latency: pattern changes appear on led on the edge after tick (same edge that clears tick_cnt). Mode change appears on mode and led one edge after the mode_next pulse.
- All counters are unsigned. No overflow beyond the wraps stated above.

Decomposition:
- Package led_pkg:
  - mode encoding constants MODE_OFF=2'd0, MODE_BLINK=2'd1, MODE_WATER=2'd2, MODE_BREATHE=2'd3;
  - DIR_UP/DIR_DOWN;
  - water seed constant.
- Sub-module tick_gen:
  - parameter T; ports clk, rst, en (=~hold), clr (=mode_next), tick.
  - Holds the 26-bit prescaler.
- Mode FSM, pattern registers and PWM stay in led_seq_ctrl.

Test Plan:
1. T=10. Release rst at 20 ns with no mode_next. Required: mode=0, led=0 for 500 cycles. tick pulses every 10 cycles, each one cycle wide.
2. One mode_next pulse. Required: mode=1 next edge, led=4'b1111. led=4'b0000 after 10 cycles, 4'b1111 after 20.
3. Second mode_next pulse. Required: mode=2, led=0001. Subsequent ticks give 0010, 0100, 1000, then 0001 (wrap).
4. In WATER at led=0100, assert hold for 35 cycles. Required: no tick and led stays 0100. After release, 0100→1000 exactly 10 cycles later.
5. mode_next pulse on the same cycle as a tick while in WATER at led=0001. Required: mode=3, duty=0, led=0 (no rotate). tick_cnt restarts, so the next tick comes 10 cycles later.
6. Run BREATHE for 600 ticks. Required: duty reaches 255 at tick 255, then 254 at tick 256, then 0 at tick 510, then 1 at tick 511. Assert rst mid-run: mode=0, led=0 immediately and asynchronously.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: display modes, breathe direction
// and the running-light seed pattern.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_WATER   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Running light starts on LED 0; widened to the LED bank width at use.
   localparam int unsigned WATER_SEED = 1;

endpackage

// File: rtl/tick_gen.sv
// Step-tick prescaler: pulses tick for one cycle every T enabled cycles.
// clr restarts the period; en=0 freezes the count and suppresses tick.
module tick_gen #(
   parameter logic [25:0] T = 26'd50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [25:0] T_LAST = T - 26'd1;

   logic [25:0] r_cnt;
   logic        w_last;

   assign w_last = (r_cnt == T_LAST);
   // tick is still flagged in a cycle where clr wins; the owner decides what to drop.
   assign tick   = en && w_last;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_last ? 26'd0 : r_cnt + 26'd1;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// Four-mode LED sequencer (off, blink, water, breathe) stepped by tick_gen,
// advanced by a one-cycle mode_next pulse and frozen by hold.
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter logic [25:0] T     = 26'd50_000_000,
   parameter int          LED_W = 4,
   parameter int          PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode_next,
   input  logic             hold,
   output logic [LED_W-1:0] led,
   output logic [1:0]       mode,
   output logic             tick
);

   localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

   mode_e            r_mode;
   dir_e             r_dir;
   logic [LED_W-1:0] r_led;
   logic [PWM_W-1:0] r_pwm_cnt;
   logic [PWM_W-1:0] r_duty;
   logic             w_tick;
   logic             w_en;
   mode_e            w_mode_nxt;

   assign w_en       = ~hold;
   assign w_mode_nxt = mode_e'(r_mode + 2'd1);

   tick_gen #(
      .T(T)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (w_en),
      .clr  (mode_next),
      .tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode    <= MODE_OFF;
         r_dir     <= DIR_UP;
         r_led     <= '0;
         r_pwm_cnt <= '0;
         r_duty    <= '0;
      end else begin
         // Free-running in every mode; hold never stops it so breathe brightness stays steady.
         r_pwm_cnt <= r_pwm_cnt + 1'b1;

         if (mode_next) begin
            // A coincident tick is discarded: the new mode starts from its seed.
            r_mode <= w_mode_nxt;
            r_dir  <= DIR_UP;
            r_duty <= '0;
            unique case (w_mode_nxt)
               MODE_OFF:     r_led <= '0;
               MODE_BLINK:   r_led <= '1;
               MODE_WATER:   r_led <= LED_W'(WATER_SEED);
               MODE_BREATHE: r_led <= '0;
            endcase
         end else begin
            unique case (r_mode)
               MODE_OFF: begin
                  r_led <= '0;
               end
               MODE_BLINK: begin
                  if (w_tick) r_led <= ~r_led;
               end
               MODE_WATER: begin
                  if (w_tick) r_led <= {r_led[LED_W-2:0], r_led[LED_W-1]};
               end
               MODE_BREATHE: begin
                  r_led <= {LED_W{r_pwm_cnt < r_duty}};
                  if (w_tick) begin
                     if (r_dir == DIR_UP) begin
                        if (r_duty == DUTY_MAX) begin
                           r_dir  <= DIR_DOWN;
                           r_duty <= r_duty - 1'b1;
                        end else begin
                           r_duty <= r_duty + 1'b1;
                        end
                     end else begin
                        if (r_duty == '0) begin
                           r_dir  <= DIR_UP;
                           r_duty <= r_duty + 1'b1;
                        end else begin
                           r_duty <= r_duty - 1'b1;
                        end
                     end
                  end
               end
            endcase
         end
      end
   end

   assign led  = r_led;
   assign mode = r_mode;
   assign tick = w_tick;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with T=10: idle, blink, water, hold,
// mode_next/tick collision, a full breathe cycle and asynchronous reset.
module tb_led_seq_ctrl;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       mode_next = 1'b0;
   logic       hold      = 1'b0;
   logic [3:0] led;
   logic [1:0] mode;
   logic       tick;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   led_seq_ctrl #(
      .T     (26'd10),
      .LED_W (4),
      .PWM_W (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_next (mode_next),
      .hold      (hold),
      .led       (led),
      .mode      (mode),
      .tick      (tick)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   logic [3:0] water_seq [6];
   logic [7:0] exp_duty;
   logic       exp_down;
   logic [7:0] prev_duty;

   initial begin
      water_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

      // Reset state while rst is high
      #12;
      check("rst_mode", 32'(mode), 32'd0);
      check("rst_led",  32'(led),  32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      #8 rst = 1'b0;

      // Idle OFF for 500 cycles; tick every 10th cycle
      for (int k = 1; k <= 500; k++) begin
         step();
         check("idle_mode", 32'(mode), 32'd0);
         check("idle_led",  32'(led),  32'd0);
         check("idle_tick", 32'(tick), (k % 10 == 9) ? 32'd1 : 32'd0);
      end

      // BLINK
      mode_next = 1'b1; step(); mode_next = 1'b0;
      check("blink_mode", 32'(mode), 32'd1);
      check("blink_init", 32'(led),  32'hf);
      steps(9);
      check("blink_tick", 32'(tick), 32'd1);
      check("blink_pre",  32'(led),  32'hf);
      step();
      check("blink_off",    32'(led),  32'h0);
      check("blink_notick", 32'(tick), 32'd0);
      steps(10);
      check("blink_on", 32'(led), 32'hf);

      // WATER
      mode_next = 1'b1; step(); mode_next = 1'b0;
      check("water_mode", 32'(mode), 32'd2);
      check("water_init", 32'(led),  32'h1);
      for (int i = 0; i < 6; i++) begin
         steps(10);
         check("water_rot", 32'(led), 32'(water_seq[i]));
      end

      // Hold at 0100 for 35 cycles
      hold = 1'b1;
      for (int i = 0; i < 35; i++) begin
         step();
         check("hold_tick", 32'(tick), 32'd0);
         check("hold_led",  32'(led),  32'h4);
      end
      hold = 1'b0;
      steps(9);
      check("rel_tick", 32'(tick), 32'd1);
      check("rel_led",  32'(led),  32'h4);
      step();
      check("rel_rot", 32'(led), 32'h8);
      steps(10);
      check("wrap_rot", 32'(led), 32'h1);

      // mode_next coincides with tick at led=0001
      steps(9);
      check("coinc_tick", 32'(tick), 32'd1);
      check("coinc_led",  32'(led),  32'h1);
      mode_next = 1'b1; step(); mode_next = 1'b0;
      check("br_mode", 32'(mode),      32'd3);
      check("br_led",  32'(led),       32'h0);
      check("br_duty", 32'(dut.r_duty), 32'd0);
      check("br_tick", 32'(tick),      32'd0);
      steps(8);
      check("br_notick", 32'(tick), 32'd0);
      step();
      check("br_tick1", 32'(tick), 32'd1);
      step();
      check("br_duty1", 32'(dut.r_duty), 32'd1);

      // BREATHE ticks 2..600
      exp_duty = 8'd1;
      exp_down = 1'b0;
      for (int n = 2; n <= 600; n++) begin
         prev_duty = exp_duty;
         for (int s = 1; s <= 10; s++) begin
            step();
            if (s == 9) check("br_tick_n", 32'(tick), 32'd1);
            if (prev_duty == 8'd0) check("br_dark", 32'(led), 32'h0);
            if (prev_duty == 8'd255)
               check("br_uniform", 32'((led == 4'h0) || (led == 4'hf)), 32'd1);
         end
         if (!exp_down) begin
            if (exp_duty == 8'd255) begin exp_down = 1'b1; exp_duty = exp_duty - 8'd1; end
            else exp_duty = exp_duty + 8'd1;
         end else begin
            if (exp_duty == 8'd0) begin exp_down = 1'b0; exp_duty = exp_duty + 8'd1; end
            else exp_duty = exp_duty - 8'd1;
         end
         check("br_duty_n", 32'(dut.r_duty), 32'(exp_duty));
         if (n == 255) check("br_peak",   32'(dut.r_duty), 32'd255);
         if (n == 256) check("br_turn",   32'(dut.r_duty), 32'd254);
         if (n == 510) check("br_floor",  32'(dut.r_duty), 32'd0);
         if (n == 511) check("br_rise",   32'(dut.r_duty), 32'd1);
         if (n == 600) check("br_end",    32'(dut.r_duty), 32'd90);
      end

      // Asynchronous reset mid-run
      steps(3);
      rst = 1'b1;
      #1;
      check("arst_mode", 32'(mode),       32'd0);
      check("arst_led",  32'(led),        32'h0);
      check("arst_tick", 32'(tick),       32'd0);
      check("arst_duty", 32'(dut.r_duty), 32'd0);
      steps(2);
      check("arst_hold_mode", 32'(mode), 32'd0);
      check("arst_hold_led",  32'(led),  32'h0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
